// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer: one 33-bit add/sub step per clock, WIDTH iterations,
// with magnitude conversion before the loop and sign fix-up after it.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod, prod_neg;

  // op[0] selects signed; magnitudes are taken from the raw latched operands in PREP
  assign a_mag     = (op_q[0] && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag     = (op_q[0] && b_q[WIDTH-1]) ? -b_q : b_q;
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
  assign div_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, b_q};
  assign prod      = {acc_hi_q, acc_lo_q};
  assign prod_neg  = -prod;

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op;
          a_d        = a;
          b_d        = b;
          div_zero_d = 1'b0;
          state_d    = S_PREP;
        end
      end
      S_PREP: begin
        neg_res_d = op_q[0] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_rem_d = op_q[0] & a_q[WIDTH-1];
        if (op_q[1] && (b_q == '0)) begin
          hi_d       = a_q;
          lo_d       = '1;
          div_zero_d = 1'b1;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end else begin
          b_d      = b_mag;
          acc_hi_d = '0;
          acc_lo_d = a_mag;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[1]) begin
          // Restoring divide: acc_hi is the remainder, acc_lo shifts in quotient bits
          if (!div_trial[WIDTH]) begin
            acc_hi_d = div_trial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = div_sh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (op_q[1]) begin
          lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      cnt_q      <= cnt_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, start/reset corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference result {div_zero, hi, lo} from plain integer arithmetic
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = {32'b0, x} * {32'b0, y}; return {1'b0, p}; end
      2'b01: begin p = 64'(sx * sy); return {1'b0, p}; end
      2'b10: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        return {1'b0, x % y, x / y};
      end
      default: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Issue one operation from IDLE (called #1 after a rising edge); optionally re-pulse start at cycle glitch_at
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int glitch_at,
                        output logic [31:0] got_hi, output logic [31:0] got_lo, output logic got_dz,
                        output int lat);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("dz_cleared_on_start", 64'(div_zero), 64'd0);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      start = (glitch_at != 0 && lat == glitch_at);
      if (start) begin op = ~o; a = ~x; b = 32'd3; end
    end
    start = 1'b0;
    if (lat >= 100) chk("done_timeout", 64'(lat), 64'd0);
    got_hi = hi; got_lo = lo; got_dz = div_zero;
    chk("busy_low_at_done", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("hold_hi_lo", {hi, lo}, {got_hi, got_lo});
  endtask

  initial begin
    logic [31:0] rh, rl;
    logic        rd;
    int          lat;
    logic [64:0] exp;
    int          done_seen;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
    vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34};
    vecs[2] = '{2'b10, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 34};
    vecs[3] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
    vecs[5] = '{2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {27'b0, busy, done, div_zero, hi, lo}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, rh, rl, rd, lat);
      chk($sformatf("vec%0d_hi", i), 64'(rh), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(rl), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_dz", i), 64'(rd), 64'(vecs[i].dz));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // A second start during RUN must be ignored
    run_op(2'b00, 32'd123456, 32'd789, 12, rh, rl, rd, lat);
    chk("glitch_result", {rh, rl}, 64'd123456 * 64'd789);
    chk("glitch_latency", 64'(lat), 64'd34);

    // Reset in the middle of RUN aborts with no done
    op = 2'b10; a = 32'hDEAD_BEEF; b = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrun_reset_outputs", {29'b0, busy, done, div_zero, hi, lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    chk("no_done_after_abort", 64'(done_seen), 64'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        default: rb = $urandom >> $urandom_range(0, 28);
      endcase
      exp = model(ro, ra, rb);
      run_op(ro, ra, rb, 0, rh, rl, rd, lat);
      chk($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), {rh, rl}, exp[63:0]);
      chk($sformatf("rand%0d_dz", i), 64'(rd), 64'(exp[64]));
      chk($sformatf("rand%0d_latency", i), 64'(lat), exp[64] ? 64'd1 : 64'd34);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
